adc_scan_sequencer: RTL and testbench

//  Round-robin scan controller for the on-board 8-channel 12-bit serial ADC (ADC_CS_N/ADC_SCLK/ADC_SADDR/ADC_SDAT).

---
 rtl/adc_scan_sequencer.sv | 168 ++++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: round-robin scan of an 8-channel 12-bit serial ADC onto a valid/ready sample port.
// Define ADC_DROP_CNT_EN to add DROP_COUNT, a saturating count of OVERRUN pulses.
module adc_scan_sequencer #(
    parameter int SCLK_DIV = 16,
    parameter int GAP_CYC  = 32
) (
    input  logic        CLK50MHZ,
    input  logic        RESET_N,
    input  logic        ENABLE,
    input  logic [7:0]  CH_MASK,
    output logic        ADC_CS_N,
    output logic        ADC_SCLK,
    output logic        ADC_SADDR,
    input  logic        ADC_SDAT,
    output logic        SAMPLE_VALID,
    input  logic        SAMPLE_READY,
    output logic [2:0]  SAMPLE_CH,
    output logic [11:0] SAMPLE_DATA,
    output logic        OVERRUN
`ifdef ADC_DROP_CNT_EN
    ,
    output logic [15:0] DROP_COUNT
`endif
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [4:0]  half_q, half_d;
    logic        sclk_q, sclk_d, saddr_q, saddr_d;
    logic [2:0]  addr_q, addr_d, tag_q, tag_d;
    logic        primed_q, primed_d, has_smp_q, has_smp_d;
    logic [10:0] shift_q, shift_d;
    logic        valid_q, valid_d, ovr_q, ovr_d;
    logic [2:0]  ch_q, ch_d;
    logic [11:0] data_q, data_d;
    logic [2:0]  start_ch, nxt_ch, idx;
    logic        go, div_end, gap_end, cap, begin_frame, fbit;

    assign go      = ENABLE && (CH_MASK != 8'h00);
    assign div_end = cnt_q == 16'(SCLK_DIV - 1);
    assign gap_end = cnt_q == 16'(GAP_CYC - 1);
    // bits f13..f11 carry the address; each goes out on the falling edge ending half-period 3/5/7
    assign fbit    = (half_q == 5'd3) ? addr_q[2] : (half_q == 5'd5) ? addr_q[1] :
                     (half_q == 5'd7) ? addr_q[0] : 1'b0;

    // search starts just past the last addressed channel, or at channel 0 after IDLE/reset
    always_comb begin
        start_ch = primed_q ? addr_q + 3'd1 : 3'd0;
        nxt_ch   = start_ch;
        idx      = start_ch;
        for (int i = 7; i >= 0; i--) begin
            idx = start_ch + 3'(i);
            if (CH_MASK[idx]) nxt_ch = idx;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 16'd1;
        half_d      = half_q;
        sclk_d      = sclk_q;
        saddr_d     = saddr_q;
        shift_d     = shift_q;
        primed_d    = primed_q;
        cap         = 1'b0;
        begin_frame = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d       = '0;
                begin_frame = go;
            end
            SETUP: if (div_end) begin
                state_d = SHIFT;
                cnt_d   = '0;
                half_d  = '0;
                sclk_d  = 1'b0;
                saddr_d = 1'b0;
            end
            SHIFT: if (div_end) begin
                cnt_d  = '0;
                half_d = half_q + 5'd1;
                if (half_q == 5'd31) begin
                    state_d = HOLD;
                end else if (sclk_q) begin
                    sclk_d  = 1'b0;
                    saddr_d = fbit;
                end else begin
                    sclk_d  = 1'b1;
                    shift_d = {shift_q[9:0], ADC_SDAT};
                    cap     = has_smp_q && (half_q == 5'd30);
                end
            end
            HOLD: if (div_end) begin
                state_d = GAP;
                cnt_d   = '0;
            end
            GAP: if (gap_end) begin
                state_d     = IDLE;
                cnt_d       = '0;
                primed_d    = 1'b0;
                begin_frame = go;
            end
            default: state_d = IDLE;
        endcase
        if (begin_frame) begin
            state_d  = SETUP;
            primed_d = 1'b1;
        end
        addr_d    = begin_frame ? nxt_ch : addr_q;
        tag_d     = begin_frame ? addr_q : tag_q;
        has_smp_d = begin_frame ? primed_q : has_smp_q;
        valid_d   = cap | (valid_q & ~SAMPLE_READY);
        ovr_d     = cap & valid_q & ~SAMPLE_READY;
        ch_d      = cap ? tag_q : ch_q;
        data_d    = cap ? {shift_q, ADC_SDAT} : data_q;
    end

    always_ff @(posedge CLK50MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            half_q    <= '0;
            sclk_q    <= 1'b1;
            saddr_q   <= 1'b0;
            addr_q    <= '0;
            tag_q     <= '0;
            primed_q  <= 1'b0;
            has_smp_q <= 1'b0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
            ch_q      <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            half_q    <= half_d;
            sclk_q    <= sclk_d;
            saddr_q   <= saddr_d;
            addr_q    <= addr_d;
            tag_q     <= tag_d;
            primed_q  <= primed_d;
            has_smp_q <= has_smp_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
            ch_q      <= ch_d;
            data_q    <= data_d;
        end
    end

    assign ADC_CS_N     = (state_q == IDLE) || (state_q == GAP);
    assign ADC_SCLK     = sclk_q;
    assign ADC_SADDR    = saddr_q;
    assign SAMPLE_VALID = valid_q;
    assign SAMPLE_CH    = ch_q;
    assign SAMPLE_DATA  = data_q;
    assign OVERRUN      = ovr_q;

`ifdef ADC_DROP_CNT_EN
    logic [15:0] drop_q;
    always_ff @(posedge CLK50MHZ or negedge RESET_N) begin
        if (!RESET_N) drop_q <= '0;
        else if (ovr_q && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
    assign DROP_COUNT = drop_q;
`endif
endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb_adc_scan_sequencer: directed bench for adc_scan_sequencer with a behavioural serial ADC model.
module tb_adc_scan_sequencer;
    logic        clk = 1'b0;
    logic        rst_n, enable, ready, sdat;
    logic [7:0]  mask;
    logic        cs_n, sclk, saddr, valid, ovr;
    logic [2:0]  ch;
    logic [11:0] data;
`ifdef ADC_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    adc_scan_sequencer dut (
        .CLK50MHZ(clk), .RESET_N(rst_n), .ENABLE(enable), .CH_MASK(mask),
        .ADC_CS_N(cs_n), .ADC_SCLK(sclk), .ADC_SADDR(saddr), .ADC_SDAT(sdat),
        .SAMPLE_VALID(valid), .SAMPLE_READY(ready), .SAMPLE_CH(ch), .SAMPLE_DATA(data),
        .OVERRUN(ovr)
`ifdef ADC_DROP_CNT_EN
        , .DROP_COUNT(drop_count)
`endif
    );

    always #10 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ADC model: returns 12'h100 + previous frame's address (plus frame number * 16 in tag_mode)
    int          bitn = 0, cs_fall = 0;
    logic [2:0]  rx_addr = '0, last_addr = '0;
    logic [11:0] word = '0;
    bit          tag_mode = 1'b0;
    logic [2:0]  addrs[$];
    logic [14:0] acc[$];
    int          acc_fr[$];

    initial sdat = 1'b0;
    always @(negedge cs_n) begin
        bitn = 0;
        cs_fall++;
        word = 12'h100 + 12'(last_addr) + (tag_mode ? {4'h0, 4'(cs_fall), 4'h0} : 12'h000);
    end
    always @(negedge sclk) begin
        logic [3:0] b;
        b = 4'(15 - bitn);
        if (!cs_n) sdat = (bitn >= 4) ? word[b] : 1'b0;
    end
    always @(posedge sclk) if (!cs_n && rst_n) begin
        if (bitn >= 2 && bitn <= 4) rx_addr = {rx_addr[1:0], saddr};
        bitn++;
    end
    always @(posedge cs_n) if (bitn == 16) begin
        last_addr = rx_addr;
        addrs.push_back(rx_addr);
    end

    int   low_run = 0, high_run = 0, last_low = 0, last_high = 0, since_rise = 0, sclk_per = 0;
    int   saddr_bad = 0, ovr_cnt = 0, ovr_long = 0;
    bit   have_rise = 1'b0;
    logic prev_cs = 1'b1, prev_sclk = 1'b1, prev_saddr = 1'b0, prev_ovr = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (!cs_n) begin
                low_run++;
                if (prev_cs) begin
                    last_high = high_run;
                    have_rise = 1'b0;
                end
                high_run = 0;
            end else begin
                high_run++;
                if (!prev_cs) last_low = low_run;
                low_run = 0;
            end
            since_rise++;
            if (!prev_sclk && sclk && !cs_n) begin
                if (have_rise) sclk_per = since_rise;
                have_rise  = 1'b1;
                since_rise = 0;
            end
            if (saddr != prev_saddr && sclk && !cs_n) saddr_bad++;
            if (valid && ready) begin
                acc.push_back({ch, data});
                acc_fr.push_back(cs_fall);
            end
            if (ovr) begin
                ovr_cnt++;
                if (prev_ovr) ovr_long++;
            end
        end
        prev_cs    = cs_n;
        prev_sclk  = sclk;
        prev_saddr = saddr;
        prev_ovr   = ovr;
    end

    task automatic do_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        addrs.delete();
        acc.delete();
        acc_fr.delete();
        cs_fall  = 0;
        ovr_cnt  = 0;
        ovr_long = 0;
        rst_n    = 1'b1;
    endtask

    task automatic wait_falls(input int n, input int budget);
        for (int i = 0; i < budget && cs_fall < n; i++) @(negedge clk);
        check("frames_reached", cs_fall, n);
    endtask

    task automatic wait_acc(input int n, input int budget);
        for (int i = 0; i < budget && acc.size() < n; i++) @(negedge clk);
        check("samples_reached", acc.size(), n);
    endtask

    task automatic wait_bit(input int n, input int budget);
        for (int i = 0; i < budget && bitn < n; i++) @(negedge clk);
        check("bit_reached", bitn, n);
    endtask

    logic [2:0]  exp_a1[4] = '{3'd0, 3'd2, 3'd0, 3'd2};
    logic [14:0] exp_s1[4] = '{{3'd0, 12'h100}, {3'd2, 12'h102}, {3'd0, 12'h100}, {3'd2, 12'h102}};

    initial begin
        rst_n = 1'b0; enable = 1'b0; ready = 1'b1; mask = 8'h05;
        repeat (3) @(negedge clk);
        check("rst_cs_n", cs_n, 1'b1);
        check("rst_sclk", sclk, 1'b1);
        check("rst_saddr", saddr, 1'b0);
        check("rst_valid", valid, 1'b0);
        check("rst_ch_data", {ch, data}, 15'd0);
        check("rst_overrun", ovr, 1'b0);

        // round robin over mask 05 with a dummy first frame
        do_reset();
        enable = 1'b1;
        wait_acc(4, 4000);
        for (int i = 0; i < 4; i++) begin
            check("frame_addr", addrs[i], exp_a1[i]);
            check("sample", acc[i], exp_s1[i]);
        end
        check("first_sample_frame", acc_fr[0], 2);
        check("cs_low_width", last_low, 544);
        check("cs_high_width", last_high, 32);
        check("sclk_period", sclk_per, 32);
        check("saddr_stable", saddr_bad, 0);
        check("no_overrun", ovr_cnt, 0);

        // back-pressure: two overwrites, latest data held
        tag_mode = 1'b1; ready = 1'b0; mask = 8'h01;
        do_reset();
        enable = 1'b1;
        wait_falls(5, 4000);
        check("overrun_pulses", ovr_cnt, 2);
        check("overrun_width", ovr_long, 0);
        check("held_valid", valid, 1'b1);
        check("held_sample", {ch, data}, {3'd0, 12'h140});
        check("none_accepted", acc.size(), 0);
`ifdef ADC_DROP_CNT_EN
        check("drop_count", drop_count, 16'd2);
`endif
        ready = 1'b1; enable = 1'b0;
        repeat (1500) @(negedge clk);
        check("drain_count", acc.size(), 2);
        check("drain_first", acc[0], {3'd0, 12'h140});
        check("drain_last", acc[1], {3'd0, 12'h150});
        check("drain_no_overrun", ovr_cnt, 2);
        check("stopped_frames", cs_fall, 5);

        // mask change while ch1 is in flight
        tag_mode = 1'b0; mask = 8'h0F;
        do_reset();
        enable = 1'b1;
        wait_falls(2, 1500);
        repeat (200) @(negedge clk);
        mask = 8'h80;
        wait_acc(3, 2500);
        check("mc_addr1", addrs[1], 3'd1);
        check("mc_addr2", addrs[2], 3'd7);
        check("mc_inflight", acc[1], {3'd1, 12'h101});
        check("mc_next", acc[2], {3'd7, 12'h107});

        // ENABLE drop mid-SHIFT, then re-enable
        mask = 8'h05;
        do_reset();
        enable = 1'b1;
        wait_falls(2, 1500);
        wait_bit(8, 800);
        enable = 1'b0;
        repeat (1500) @(negedge clk);
        check("stop_frames", cs_fall, 2);
        check("stop_samples", acc.size(), 1);
        check("stop_sample", acc[0], {3'd0, 12'h100});
        check("stop_cs_n", cs_n, 1'b1);
        check("stop_valid", valid, 1'b0);
        enable = 1'b1;
        wait_acc(2, 2500);
        check("reen_frame", acc_fr[1], 4);
        check("reen_sample", acc[1], {3'd0, 12'h100});

        // async reset mid-SHIFT
        ready = 1'b0; mask = 8'h06;
        do_reset();
        enable = 1'b1;
        wait_falls(3, 2500);
        wait_bit(4, 400);
        check("pre_rst_valid", valid, 1'b1);
        check("pre_rst_sample", {ch, data}, {3'd1, 12'h101});
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_cs_n", cs_n, 1'b1);
        check("arst_sclk", sclk, 1'b1);
        check("arst_valid", valid, 1'b0);
        ready = 1'b1;
        do_reset();
        enable = 1'b1;
        wait_acc(1, 2000);
        check("restart_addr", addrs[0], 3'd1);
        check("restart_sample", acc[0], {3'd1, 12'h101});
        check("restart_frame", acc_fr[0], 2);
        check("saddr_stable_end", saddr_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
